bit_serial_alu_ctrl: RTL and testbench

BIT_SERIAL_ALU_CTRL -- requirements
Module: bit_serial_alu_ctrl

---
 rtl/bit_serial_pkg.sv | 6 +
 rtl/serial_alu_slice.sv | 14 +
 rtl/bit_serial_alu_ctrl.sv | 95 +++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// bit_serial_pkg: shared op codes, FSM states and default width for the bit-serial ALU.
package bit_serial_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10} state_t;
endpackage

// File: rtl/serial_alu_slice.sv
// serial_alu_slice: 1-bit full adder for ADD/SUB, bitwise AND/OR otherwise.
module serial_alu_slice (
  input  logic       at,
  input  logic       bt,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       r,
  output logic       cout
);
  always_comb begin
    r    = op[1] ? (op[0] ? (at | bt) : (at & bt)) : (at ^ bt ^ cin);
    cout = op[1] ? 1'b0 : ((at & bt) | (cin & (at ^ bt)));
  end
endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl: LSB-first bit-serial ADD/SUB/AND/OR with Z/N/C/V flags.
// One bit per cycle; result and flags are committed only on the last bit.
module bit_serial_alu_ctrl
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] acc;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry, bt, r, cout;
  logic [WIDTH-1:0] nxt;
  always_comb begin
    bt  = sb[0] ^ (op_q == OP_SUB);
    nxt = {r, acc};
  end
  serial_alu_slice u_slice (
    .at  (sa[0]),
    .bt  (bt),
    .cin (carry),
    .op  (op_q),
    .r   (r),
    .cout(cout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          sa    <= a;
          sb    <= b;
          op_q  <= op;
          cnt   <= '0;
          carry <= op[0];
          busy  <= 1'b1;
          state <= S_RUN;
        end
        S_RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          acc <= nxt[WIDTH-1:1];
          cnt <= cnt + CW'(1);
          if (!op_q[1]) carry <= cout;
          // carry still holds the carry into the MSB on the last bit
          if (cnt == CW'(WIDTH-1)) begin
            result <= nxt;
            flag_z <= ~|nxt;
            flag_n <= r;
            flag_c <= ~op_q[1] & cout;
            flag_v <= ~op_q[1] & (carry ^ cout);
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// tb_bit_serial_alu_ctrl: directed checks of the bit-serial ALU at WIDTH=8.
module tb_bit_serial_alu_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done, flag_z, flag_n, flag_c, flag_v;
  logic [7:0] result;
  int total = 0, fails = 0;
  int lat, k, dcount, dk, d1, d2, d3;
  bit_serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int l);
    repeat (2) @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    l = 0;
    while (done !== 1'b1 && l < 20) begin
      @(posedge clk);
      #1 l++;
    end
  endtask
  initial begin
    #12;
    chk("reset_out", {busy, done, result, flag_z, flag_n, flag_c, flag_v}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    run_op(2'b00, 8'h7F, 8'h01, lat);
    chk("add_lat", lat, 8);
    chk("add_res", result, 8'h80);
    chk("add_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);
    chk("add_busy", busy, 1'b1);
    run_op(2'b01, 8'h05, 8'h05, lat);
    chk("sub_eq_res", result, 8'h00);
    chk("sub_eq_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);
    run_op(2'b01, 8'h00, 8'h01, lat);
    chk("sub_brw_res", result, 8'hFF);
    chk("sub_brw_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0100);
    run_op(2'b10, 8'hF0, 8'h0F, lat);
    chk("and_res", result, 8'h00);
    chk("and_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1000);
    run_op(2'b11, 8'hF0, 8'h0F, lat);
    chk("or_res", result, 8'hFF);
    chk("or_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0100);
    run_op(2'b00, 8'h80, 8'h80, lat);
    chk("add_ovf_res", result, 8'h00);
    chk("add_ovf_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1011);
    run_op(2'b01, 8'h80, 8'h01, lat);
    chk("sub_ovf_res", result, 8'h7F);
    chk("sub_ovf_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0011);
    // start and operands wiggled mid-run must not restart or corrupt
    repeat (2) @(negedge clk);
    op = 2'b00; a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcount = 0; dk = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'b11; end
      if (i == 5) start = 1'b0;
      if (done === 1'b1) begin dcount++; dk = i; end
    end
    chk("ign_count", dcount, 1);
    chk("ign_lat", dk, 8);
    chk("ign_res", result, 8'h46);
    chk("ign_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    chk("ign_idle", busy, 1'b0);
    run_op(2'b01, 8'h00, 8'h01, lat);
    chk("pre_rst_res", result, 8'hFF);
    repeat (2) @(negedge clk);
    op = 2'b00; a = 8'h7F; b = 8'h01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", {busy, done, result, flag_z, flag_n, flag_c, flag_v}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    run_op(2'b00, 8'h01, 8'h01, lat);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_res", result, 8'h02);
    chk("post_rst_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    // held start: accepted every WIDTH+2 cycles
    repeat (2) @(negedge clk);
    op = 2'b00; a = 8'h01; b = 8'h02; start = 1'b1;
    dcount = 0; d1 = 0; d2 = 0; d3 = 0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dcount++;
        if (dcount == 1) d1 = i; else if (dcount == 2) d2 = i; else d3 = i;
        chk("b2b_res", result, 8'h03);
      end
    end
    start = 1'b0;
    chk("b2b_count", dcount, 3);
    chk("b2b_first", d1, 9);
    chk("b2b_gap1", d2 - d1, 10);
    chk("b2b_gap2", d3 - d2, 10);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
